binary_mul_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one registered unsigned multiplier (A,B,P,clk,rst_n,en) among NREQ requesters.

---
 rtl/binary_mul_rr_sched_if.sv | 31 +++
 rtl/binary_mul_rr_sched.sv | 113 +++++++++++
 tb/tb_binary_mul_rr_sched.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/binary_mul_rr_sched_if.sv
// Bundle of request, multiplier and response signals for the round-robin multiplier scheduler.
// The slave modport is the scheduler's view. The master modport is the client/multiplier side.
interface binary_mul_rr_sched_if #(
    parameter int W    = 12,
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_en;
    logic [2*W-1:0]    mul_p;
    logic              resp_valid;
    logic              resp_ready;
    logic [2*W-1:0]    resp_p;
    logic [IDW-1:0]    resp_id;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_p, resp_ready,
        output req_ready, mul_a, mul_b, mul_en, resp_valid, resp_p, resp_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_p, resp_ready,
        input  req_ready, mul_a, mul_b, mul_en, resp_valid, resp_p, resp_id, busy
    );
endinterface

// File: rtl/binary_mul_rr_sched.sv
// Round-robin scheduler that time-shares one external registered multiplier among NREQ requesters.
// It runs one operation at a time: grant, enable the multiplier for MUL_LAT edges, capture, respond.
module binary_mul_rr_sched #(
    parameter int  W       = 12,
    parameter int  NREQ    = 4,
    parameter int  MUL_LAT = 1,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    binary_mul_rr_sched_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_e;

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [CW-1:0]   lat_cnt_q;
    logic [W-1:0]    mul_a_q;
    logic [W-1:0]    mul_b_q;
    logic            mul_en_q;
    logic            resp_valid_q;
    logic [2*W-1:0]  resp_p_q;
    logic [IDW-1:0]  resp_id_q;

    logic            grant_valid_d;
    logic [IDW-1:0]  grant_idx_d;
    logic [IDW-1:0]  ptr_d;
    logic [W-1:0]    grant_a_d;
    logic [W-1:0]    grant_b_d;
    int              idx;

    // Scan from the highest offset down so the valid requester closest to ptr_q is the one kept.
    // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        grant_valid_d = 1'b0;
        grant_idx_d   = '0;
        idx           = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req_valid[idx]) begin
                grant_valid_d = 1'b1;
                grant_idx_d   = IDW'(idx);
            end
        end
        ptr_d     = (int'(grant_idx_d) == NREQ - 1) ? '0 : grant_idx_d + 1'b1;
        grant_a_d = bus.req_a[int'(grant_idx_d)*W +: W];
        grant_b_d = bus.req_b[int'(grant_idx_d)*W +: W];
    end

    // NOTE: the operand and product registers are reset as well, so they read 0 after reset.
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            lat_cnt_q    <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_p_q     <= '0;
            resp_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid_d) begin
                        mul_a_q   <= grant_a_d;
                        mul_b_q   <= grant_b_d;
                        resp_id_q <= grant_idx_d;
                        ptr_q     <= ptr_d;
                        lat_cnt_q <= '0;
                        mul_en_q  <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_cnt_q == CW'(MUL_LAT - 1)) begin
                        mul_en_q <= 1'b0;
                        state_q  <= CAPT;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                CAPT: begin
                    resp_p_q     <= bus.mul_p;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The grant is offered only while idle and out of reset. The one-hot ready never lasts past the handshake.
    assign bus.req_ready  = (rst_n && state_q == IDLE && grant_valid_d) ? (NREQ'(1) << grant_idx_d) : '0;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.mul_en     = mul_en_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_p     = resp_p_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_binary_mul_rr_sched.sv
// Bench for binary_mul_rr_sched: instance 0 uses MUL_LAT=1 and instance 1 uses MUL_LAT=3.
// A timeline model measures cycles since each grant. One negedge process compares every output of both instances.
module tb_binary_mul_rr_sched;

    localparam int LAT [2] = '{1, 3};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    binary_mul_rr_sched_if #(.W(12), .NREQ(4)) bus0 ();
    binary_mul_rr_sched_if #(.W(12), .NREQ(4)) bus1 ();

    binary_mul_rr_sched #(.W(12), .NREQ(4), .MUL_LAT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    binary_mul_rr_sched #(.W(12), .NREQ(4), .MUL_LAT(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // Stimulus arrays, one entry per instance.
    logic [3:0]  rv [2] = '{4'h0, 4'h0};
    logic [47:0] ra [2] = '{48'h0, 48'h0};
    logic [47:0] rb [2] = '{48'h0, 48'h0};
    logic        rr [2] = '{1'b0, 1'b0};

    assign bus0.req_valid = rv[0];
    assign bus0.req_a = ra[0];
    assign bus0.req_b = rb[0];
    assign bus0.resp_ready = rr[0];
    assign bus1.req_valid = rv[1];
    assign bus1.req_a = ra[1];
    assign bus1.req_b = rb[1];
    assign bus1.resp_ready = rr[1];

    // External registered multipliers: one stage for instance 0, three stages for instance 1.
    logic [23:0] p0, s1, s2, s3;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 <= '0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            if (bus0.mul_en) p0 <= bus0.mul_a * bus0.mul_b;
            if (bus1.mul_en) begin
                s1 <= bus1.mul_a * bus1.mul_b;
                s2 <= s1;
                s3 <= s2;
            end
        end
    end
    assign bus0.mul_p = p0;
    assign bus1.mul_p = s3;

    logic [3:0]  o_rdy [2];
    logic [11:0] o_ma [2];
    logic [11:0] o_mb [2];
    logic        o_en [2];
    logic        o_rv [2];
    logic        o_busy [2];
    logic [23:0] o_rp [2];
    logic [1:0]  o_id [2];
    assign o_rdy[0] = bus0.req_ready;
    assign o_rdy[1] = bus1.req_ready;
    assign o_ma[0] = bus0.mul_a;
    assign o_ma[1] = bus1.mul_a;
    assign o_mb[0] = bus0.mul_b;
    assign o_mb[1] = bus1.mul_b;
    assign o_en[0] = bus0.mul_en;
    assign o_en[1] = bus1.mul_en;
    assign o_rv[0] = bus0.resp_valid;
    assign o_rv[1] = bus1.resp_valid;
    assign o_busy[0] = bus0.busy;
    assign o_busy[1] = bus1.busy;
    assign o_rp[0] = bus0.resp_p;
    assign o_rp[1] = bus1.resp_p;
    assign o_id[0] = bus0.resp_id;
    assign o_id[1] = bus1.resp_id;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int ptr);
        for (int i = 0; i < 4; i++)
            if (v[(ptr + i) % 4]) return (ptr + i) % 4;
        return -1;
    endfunction

    // Model state: whether an operation is in flight and how many edges have passed since its grant.
    bit     m_act [2] = '{1'b0, 1'b0};
    int     m_t   [2] = '{0, 0};
    int     m_ptr [2] = '{0, 0};
    int     m_id  [2] = '{0, 0};
    longint m_a   [2] = '{0, 0};
    longint m_b   [2] = '{0, 0};
    longint m_rp  [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_act[k] <= 1'b0;
                m_t[k]   <= 0;
                m_ptr[k] <= 0;
                m_id[k]  <= 0;
                m_a[k]   <= 0;
                m_b[k]   <= 0;
                m_rp[k]  <= 0;
            end else if (!m_act[k]) begin
                if (rr_pick(rv[k], m_ptr[k]) >= 0) begin
                    m_act[k] <= 1'b1;
                    m_t[k]   <= 1;
                    m_id[k]  <= rr_pick(rv[k], m_ptr[k]);
                    m_a[k]   <= longint'(ra[k][rr_pick(rv[k], m_ptr[k])*12 +: 12]);
                    m_b[k]   <= longint'(rb[k][rr_pick(rv[k], m_ptr[k])*12 +: 12]);
                    m_ptr[k] <= (rr_pick(rv[k], m_ptr[k]) + 1) % 4;
                end
            end else if (m_t[k] >= LAT[k] + 2 && rr[k]) begin
                m_act[k] <= 1'b0;
            end else begin
                m_t[k] <= m_t[k] + 1;
                if (m_t[k] == LAT[k] + 1) m_rp[k] <= m_a[k] * m_b[k];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int pk;
            logic [3:0] er;
            pk = rr_pick(rv[k], m_ptr[k]);
            er = (rst_n && !m_act[k] && pk >= 0) ? 4'(1 << pk) : 4'b0;
            check($sformatf("d%0d req_ready", k), longint'(o_rdy[k]), longint'(er));
            check($sformatf("d%0d busy", k), longint'(o_busy[k]), longint'(m_act[k]));
            check($sformatf("d%0d mul_en", k), longint'(o_en[k]), longint'(m_act[k] && m_t[k] <= LAT[k]));
            check($sformatf("d%0d resp_valid", k), longint'(o_rv[k]), longint'(m_act[k] && m_t[k] >= LAT[k] + 2));
            check($sformatf("d%0d mul_a", k), longint'(o_ma[k]), m_a[k]);
            check($sformatf("d%0d mul_b", k), longint'(o_mb[k]), m_b[k]);
            check($sformatf("d%0d resp_p", k), longint'(o_rp[k]), m_rp[k]);
            check($sformatf("d%0d resp_id", k), longint'(o_id[k]), longint'(m_id[k]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single operation from requester idx. Counts edges from the ready cycle to resp_valid and the cycles with mul_en high.
    task automatic run_op(input int k, input int idx, input int a, input int b,
                          output int n, output int en_cnt);
        rv[k] = 4'(1 << idx);
        ra[k][idx*12 +: 12] = 12'(a);
        rb[k][idx*12 +: 12] = 12'(b);
        #1;
        check($sformatf("d%0d op ready", k), longint'(o_rdy[k]), longint'(4'(1 << idx)));
        n = 0;
        en_cnt = 0;
        do begin
            cyc(1);
            n++;
            if (n == 1) rv[k] = 4'h0;
            if (o_en[k]) en_cnt++;
        end while (!o_rv[k] && n < 30);
    endtask

    int n, en_cnt;
    int grants[$];
    int gcyc[$];
    longint prods[$];
    bit saw_rv;

    initial begin
        // Test 1: random inputs while in reset, then release with nothing valid.
        rv[0] = 4'($urandom());
        ra[0] = 48'({$urandom(), $urandom()});
        rb[0] = 48'({$urandom(), $urandom()});
        rr[0] = 1'($urandom());
        cyc(3);
        check("reset req_ready", longint'(o_rdy[0]), 0);
        check("reset resp_p", longint'(o_rp[0]), 0);
        rv[0] = 4'h0;
        rr[0] = 1'b0;
        rst_n = 1'b1;
        cyc(3);
        check("idle busy", longint'(o_busy[0]), 0);

        // Test 2: only requester 2, full-scale operands.
        run_op(0, 2, 4095, 4095, n, en_cnt);
        check("t2 latency", n, 3);
        check("t2 en cycles", en_cnt, 1);
        check("t2 resp_p", longint'(o_rp[0]), 16769025);
        check("t2 resp_id", longint'(o_id[0]), 2);
        rr[0] = 1'b1;
        cyc(1);
        rr[0] = 1'b0;

        // Restart the pointer at 0 before the rotation test.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // Test 3: all four requesters valid, consumer always ready.
        for (int i = 0; i < 4; i++) begin
            ra[0][i*12 +: 12] = 12'(i + 1);
            rb[0][i*12 +: 12] = 12'd10;
        end
        rv[0] = 4'hF;
        rr[0] = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (o_rdy[0] != 4'h0) begin
                grants.push_back($clog2(int'(o_rdy[0])));
                gcyc.push_back(c);
            end
            if (o_rv[0]) prods.push_back(longint'(o_rp[0]));
            cyc(1);
        end
        rv[0] = 4'h0;
        check("t3 grant count", grants.size(), 5);
        check("t3 resp count", prods.size(), 5);
        for (int i = 0; i < 5 && i < grants.size() && i < prods.size(); i++) begin
            check($sformatf("t3 grant %0d", i), grants[i], i % 4);
            check($sformatf("t3 gap %0d", i), gcyc[i], 4 * i);
            check($sformatf("t3 prod %0d", i), prods[i], 10 * ((i % 4) + 1));
        end
        cyc(4);
        rr[0] = 1'b0;

        // Test 4: response back-pressure while requester 1 keeps asking.
        ra[0][12 +: 12] = 12'd7;
        rb[0][12 +: 12] = 12'd9;
        rv[0] = 4'b0010;
        #1;
        check("t4 ready", longint'(o_rdy[0]), 4'b0010);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!o_rv[0] && n < 30);
        check("t4 latency", n, 3);
        for (int i = 0; i < 5; i++) begin
            check("t4 hold valid", longint'(o_rv[0]), 1);
            check("t4 hold p", longint'(o_rp[0]), 63);
            check("t4 hold id", longint'(o_id[0]), 1);
            check("t4 hold ready", longint'(o_rdy[0]), 0);
            cyc(1);
        end
        rr[0] = 1'b1;
        cyc(1);
        rr[0] = 1'b0;
        check("t4 regrant", longint'(o_rdy[0]), 4'b0010);
        rv[0] = 4'h0;
        cyc(2);

        // Test 5: reset pulse during ISSUE drops the operation and rewinds the pointer.
        ra[0][36 +: 12] = 12'd5;
        rb[0][36 +: 12] = 12'd5;
        rv[0] = 4'b1000;
        #1;
        check("t5 ready", longint'(o_rdy[0]), 4'b1000);
        cyc(1);
        rv[0] = 4'h0;
        check("t5 issue en", longint'(o_en[0]), 1);
        rst_n = 1'b0;
        #1;
        check("t5 rst busy", longint'(o_busy[0]), 0);
        check("t5 rst en", longint'(o_en[0]), 0);
        check("t5 rst mul_a", longint'(o_ma[0]), 0);
        check("t5 rst id", longint'(o_id[0]), 0);
        #1;
        rst_n = 1'b1;
        saw_rv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (o_rv[0]) saw_rv = 1'b1;
        end
        check("t5 no resp", longint'(saw_rv), 0);
        rv[0] = 4'b1010;
        #1;
        check("t5 ptr restart", longint'(o_rdy[0]), 4'b0010);
        cyc(1);
        rv[0] = 4'h0;
        rr[0] = 1'b1;
        cyc(5);
        rr[0] = 1'b0;

        // Test 6: three-edge multiplier latency.
        run_op(1, 0, 0, 4095, n, en_cnt);
        check("t6a latency", n, 5);
        check("t6a en cycles", en_cnt, 3);
        check("t6a resp_p", longint'(o_rp[1]), 0);
        rr[1] = 1'b1;
        cyc(1);
        rr[1] = 1'b0;
        run_op(1, 0, 1, 4095, n, en_cnt);
        check("t6b latency", n, 5);
        check("t6b en cycles", en_cnt, 3);
        check("t6b resp_p", longint'(o_rp[1]), 4095);
        rr[1] = 1'b1;
        cyc(1);
        rr[1] = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
